// File: rtl/inst_queue_pkg.sv
// Shared widths, entry type and helpers for the instruction queue.
// Optional performance counter is enabled by defining INST_QUEUE_PERF_EN.
`ifndef PC_BUS
`define PC_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef DECODE_BUS
`define DECODE_BUS 71:0
`endif

package inst_queue_pkg;

    typedef struct packed {
        logic [`PC_BUS]     pc;
        logic [`PC_BUS]     npc;
        logic [`DECODE_BUS] dec;
    } iq_entry_t;

    localparam int ENTRY_W = $bits(iq_entry_t);

    // The launch stage can never take more than two entries per cycle.
    function automatic logic [1:0] clamp_pop(input logic [1:0] n);
        return (n == 2'd3) ? 2'd2 : n;
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Push/pop handshake bundle between fetch/decode, the instruction queue and launch select.
interface inst_queue_if;
    logic               flush;
    logic               stop;
    logic               in1_valid;
    logic               in2_valid;
    logic [`PC_BUS]     in1_pc;
    logic [`PC_BUS]     in1_npc;
    logic [`PC_BUS]     in2_pc;
    logic [`PC_BUS]     in2_npc;
    logic [`DECODE_BUS] in1_decodeout;
    logic [`DECODE_BUS] in2_decodeout;
    logic               in_ready;
    logic               out1_valid;
    logic               out2_valid;
    logic [`PC_BUS]     out1_pc;
    logic [`PC_BUS]     out1_npc;
    logic [`PC_BUS]     out2_pc;
    logic [`PC_BUS]     out2_npc;
    logic [`DECODE_BUS] out1_decodeout;
    logic [`DECODE_BUS] out2_decodeout;
    logic [1:0]         pop_num;

    modport master (
        output flush, stop, in1_valid, in2_valid,
        output in1_pc, in1_npc, in2_pc, in2_npc, in1_decodeout, in2_decodeout,
        output pop_num,
        input  in_ready, out1_valid, out2_valid,
        input  out1_pc, out1_npc, out2_pc, out2_npc, out1_decodeout, out2_decodeout
    );

    modport slave (
        input  flush, stop, in1_valid, in2_valid,
        input  in1_pc, in1_npc, in2_pc, in2_npc, in1_decodeout, in2_decodeout,
        input  pop_num,
        output in_ready, out1_valid, out2_valid,
        output out1_pc, out1_npc, out2_pc, out2_npc, out1_decodeout, out2_decodeout
    );
endinterface

// File: rtl/iq_ram.sv
// Instruction queue storage: DEPTH entries, two write ports, two asynchronous read ports.
// Contents are deliberately not reset; the queue masks stale entries with its valids.
module iq_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we0,
    input  logic [AW-1:0] i_wa0,
    input  iq_entry_t     i_wd0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_wa1,
    input  iq_entry_t     i_wd1,
    input  logic [AW-1:0] i_ra0,
    input  logic [AW-1:0] i_ra1,
    output iq_entry_t     o_rd0,
    output iq_entry_t     o_rd1
);

    iq_entry_t r_mem [DEPTH];

    // The two write addresses are always consecutive, so they never collide.
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_wa0] <= i_wd0;
        if (i_we1) r_mem[i_wa1] <= i_wd1;
    end

    assign o_rd0 = r_mem[i_ra0];
    assign o_rd1 = r_mem[i_ra1];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue: circular buffer with head/tail/count, 2 pushes and up to 2 pops per cycle.
// Define INST_QUEUE_PERF_EN to add the full_stall_cnt performance counter output.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  iq
`ifdef INST_QUEUE_PERF_EN
    ,
    output logic [31:0]  full_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_in_ready;
    logic          w_push1;
    logic          w_push2;
    logic [1:0]    w_n_push;
    logic [1:0]    w_pop_req;
    logic [1:0]    w_n_pop;
    logic          w_out1_valid;
    logic          w_out2_valid;
    iq_entry_t     w_wd0;
    iq_entry_t     w_wd1;
    iq_entry_t     w_rd0;
    iq_entry_t     w_rd1;
    iq_entry_t     w_out1;
    iq_entry_t     w_out2;

    // Readiness looks only at the registered count so a same-cycle pop cannot open the door.
    assign w_in_ready = (r_count <= CW'(DEPTH - 2));
    assign w_push1    = w_in_ready & ~iq.flush & iq.in1_valid;
    assign w_push2    = w_push1 & iq.in2_valid;
    assign w_n_push   = {1'b0, w_push1} + {1'b0, w_push2};
    assign w_pop_req  = clamp_pop(iq.pop_num);

    always_comb begin
        w_n_pop = 2'd0;
        if (!iq.stop && !iq.flush) begin
            w_n_pop = (CW'(w_pop_req) > r_count) ? r_count[1:0] : w_pop_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (iq.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_n_pop);
            r_tail  <= r_tail + AW'(w_n_push);
            r_count <= r_count + CW'(w_n_push) - CW'(w_n_pop);
        end
    end

    assign w_wd0 = '{pc: iq.in1_pc, npc: iq.in1_npc, dec: iq.in1_decodeout};
    assign w_wd1 = '{pc: iq.in2_pc, npc: iq.in2_npc, dec: iq.in2_decodeout};

    iq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .i_we0 (w_push1),
        .i_wa0 (r_tail),
        .i_wd0 (w_wd0),
        .i_we1 (w_push2),
        .i_wa1 (r_tail + AW'(1)),
        .i_wd1 (w_wd1),
        .i_ra0 (r_head),
        .i_ra1 (r_head + AW'(1)),
        .o_rd0 (w_rd0),
        .o_rd1 (w_rd1)
    );

    assign w_out1_valid = (r_count >= CW'(1));
    assign w_out2_valid = (r_count >= CW'(2));
    assign w_out1       = w_out1_valid ? w_rd0 : '0;
    assign w_out2       = w_out2_valid ? w_rd1 : '0;

    assign iq.in_ready       = w_in_ready;
    assign iq.out1_valid     = w_out1_valid;
    assign iq.out2_valid     = w_out2_valid;
    assign iq.out1_pc        = w_out1.pc;
    assign iq.out1_npc       = w_out1.npc;
    assign iq.out1_decodeout = w_out1.dec;
    assign iq.out2_pc        = w_out2.pc;
    assign iq.out2_npc       = w_out2.npc;
    assign iq.out2_decodeout = w_out2.dec;

`ifdef INST_QUEUE_PERF_EN
    logic [31:0] r_full_stall_cnt;

    // Counts producer back-pressure cycles; intentionally ignores flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full_stall_cnt <= '0;
        end else if (!w_in_ready && iq.in1_valid) begin
            r_full_stall_cnt <= r_full_stall_cnt + 32'd1;
        end
    end

    assign full_stall_cnt = r_full_stall_cnt;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based reference model plus directed scenarios.
module tb_inst_queue;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [71:0] dec;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_queue_if iq();

`ifdef INST_QUEUE_PERF_EN
    logic [31:0] full_stall_cnt;
`endif

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .iq  (iq)
`ifdef INST_QUEUE_PERF_EN
        ,
        .full_stall_cnt (full_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an ordered list of entries plus a stall counter.
    ent_t        mq[$];
    logic [31:0] m_stall;

    always @(posedge clk or negedge rst) begin
        int sz;
        int pr;
        int np;
        if (!rst) begin
            mq.delete();
            m_stall = 32'd0;
        end else begin
            sz = mq.size();
            if (sz > DEPTH - 2 && iq.in1_valid) m_stall = m_stall + 32'd1;
            if (iq.flush) begin
                mq.delete();
            end else begin
                pr = (iq.pop_num == 2'd3) ? 2 : int'(iq.pop_num);
                np = iq.stop ? 0 : ((pr < sz) ? pr : sz);
                repeat (np) void'(mq.pop_front());
                if (sz <= DEPTH - 2 && iq.in1_valid) begin
                    mq.push_back('{iq.in1_pc, iq.in1_npc, iq.in1_decodeout});
                    if (iq.in2_valid) mq.push_back('{iq.in2_pc, iq.in2_npc, iq.in2_decodeout});
                end
            end
        end
    end

    always @(negedge clk) begin
        ent_t e1;
        ent_t e2;
        logic v1;
        logic v2;
        v1 = (mq.size() >= 1);
        v2 = (mq.size() >= 2);
        e1 = v1 ? mq[0] : '0;
        e2 = v2 ? mq[1] : '0;
        chk("out1_valid", 72'(iq.out1_valid), 72'(v1));
        chk("out2_valid", 72'(iq.out2_valid), 72'(v2));
        chk("in_ready",   72'(iq.in_ready),   72'(mq.size() <= DEPTH - 2));
        chk("out1_pc",    72'(iq.out1_pc),    72'(e1.pc));
        chk("out1_npc",   72'(iq.out1_npc),   72'(e1.npc));
        chk("out1_dec",   iq.out1_decodeout,  e1.dec);
        chk("out2_pc",    72'(iq.out2_pc),    72'(e2.pc));
        chk("out2_npc",   72'(iq.out2_npc),   72'(e2.npc));
        chk("out2_dec",   iq.out2_decodeout,  e2.dec);
`ifdef INST_QUEUE_PERF_EN
        chk("full_stall_cnt", 72'(full_stall_cnt), 72'(m_stall));
`endif
    end

    task automatic idle();
        iq.flush         = 1'b0;
        iq.stop          = 1'b0;
        iq.in1_valid     = 1'b0;
        iq.in2_valid     = 1'b0;
        iq.in1_pc        = '0;
        iq.in1_npc       = '0;
        iq.in2_pc        = '0;
        iq.in2_npc       = '0;
        iq.in1_decodeout = '0;
        iq.in2_decodeout = '0;
        iq.pop_num       = 2'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set1(input logic [31:0] pa);
        iq.in1_valid     = 1'b1;
        iq.in1_pc        = pa;
        iq.in1_npc       = pa + 32'd4;
        iq.in1_decodeout = {8'hA5, ~pa, pa};
    endtask

    task automatic set2(input logic [31:0] pa, input logic [31:0] pb);
        set1(pa);
        iq.in2_valid     = 1'b1;
        iq.in2_pc        = pb;
        iq.in2_npc       = pb + 32'd4;
        iq.in2_decodeout = {8'h5A, ~pb, pb};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out1_valid", 72'(iq.out1_valid), 72'd0);
        chk("rst_out2_valid", 72'(iq.out2_valid), 72'd0);
        chk("rst_in_ready",   72'(iq.in_ready),   72'd1);
        chk("rst_out1_pc",    72'(iq.out1_pc),    72'd0);
        rst = 1'b1;

        // First pair after reset release
        set2(32'h100, 32'h104);
        cyc();
        idle();
        chk("first_out1_pc",  72'(iq.out1_pc),    72'h100);
        chk("first_out2_pc",  72'(iq.out2_pc),    72'h104);
        chk("first_out1_npc", 72'(iq.out1_npc),   72'h104);
        chk("first_valids",   72'({iq.out1_valid, iq.out2_valid}), 72'b11);
        chk("first_ready",    72'(iq.in_ready),   72'd1);

        iq.flush = 1'b1;
        cyc();
        idle();
        chk("flush_empty", 72'(iq.out1_valid), 72'd0);

        // Fill to DEPTH with pairs, no pops
        for (int i = 0; i < 4; i++) begin
            set2(32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i));
            cyc();
        end
        idle();
        chk("full_ready", 72'(iq.in_ready), 72'd0);
        set2(32'h2000, 32'h2004);
        cyc();
        idle();
        chk("full_ignore_ready", 72'(iq.in_ready), 72'd0);
        chk("full_ignore_head",  72'(iq.out1_pc),  72'h1000);
        iq.pop_num = 2'd1;
        cyc();
        idle();
        chk("cnt7_ready", 72'(iq.in_ready), 72'd0);
        chk("cnt7_head",  72'(iq.out1_pc),  72'h1004);

        // count=7: push blocked, pop 2 -> count 5
        set2(32'h3000, 32'h3004);
        iq.pop_num = 2'd2;
        cyc();
        idle();
        chk("cnt5_ready", 72'(iq.in_ready), 72'd1);
        chk("cnt5_head",  72'(iq.out1_pc),  72'h100C);
        chk("cnt5_next",  72'(iq.out2_pc),  72'h1010);

        // Flush wins over push and pop
        set2(32'h4000, 32'h4004);
        iq.pop_num = 2'd2;
        iq.flush   = 1'b1;
        cyc();
        idle();
        chk("flush_valids", 72'({iq.out1_valid, iq.out2_valid}), 72'b00);
        chk("flush_out1_pc", 72'(iq.out1_pc), 72'd0);
        chk("flush_out2_dec", iq.out2_decodeout, 72'd0);
        chk("flush_ready", 72'(iq.in_ready), 72'd1);

        // Stall holds the queue
        set2(32'h500, 32'h504);
        cyc();
        idle();
        set1(32'h508);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            iq.stop    = 1'b1;
            iq.pop_num = 2'd2;
            cyc();
            chk("stop_head", 72'(iq.out1_pc), 72'h500);
        end
        idle();
        iq.pop_num = 2'd2;
        cyc();
        idle();
        chk("unstop_valids", 72'({iq.out1_valid, iq.out2_valid}), 72'b10);
        chk("unstop_head",   72'(iq.out1_pc), 72'h508);

        // pop_num=3 behaves as 2; in2 alone is ignored
        set2(32'h600, 32'h604);
        cyc();
        idle();
        iq.pop_num = 2'd3;
        cyc();
        idle();
        chk("pop3_head",   72'(iq.out1_pc),   72'h604);
        chk("pop3_out2v",  72'(iq.out2_valid), 72'd0);
        iq.in2_valid = 1'b1;
        iq.in2_pc    = 32'h700;
        cyc();
        idle();
        chk("in2_only_out2v", 72'(iq.out2_valid), 72'd0);
        iq.pop_num = 2'd3;
        cyc();
        idle();
        chk("pop3_empty", 72'(iq.out1_valid), 72'd0);

        // Wrap-around: 20 sequential PCs, one pop per cycle
        k = 0;
        for (int i = 0; i < 20; i++) begin
            set1(32'(4 * i));
            iq.pop_num = 2'd1;
            if (iq.out1_valid) begin
                chk("wrap_order", 72'(iq.out1_pc), 72'(4 * k));
                k++;
            end
            cyc();
        end
        idle();
        iq.pop_num = 2'd1;
        for (int g = 0; g < 10 && k < 20; g++) begin
            if (iq.out1_valid) begin
                chk("wrap_order", 72'(iq.out1_pc), 72'(4 * k));
                k++;
            end
            cyc();
        end
        idle();
        chk("wrap_count", 72'(k), 72'd20);

        // Asynchronous reset mid-operation
        set2(32'h800, 32'h804);
        cyc();
        set2(32'h808, 32'h80C);
        cyc();
        idle();
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", 72'(iq.out1_valid), 72'd0);
        chk("async_rst_ready", 72'(iq.in_ready),   72'd1);
        chk("async_rst_pc",    72'(iq.out1_pc),    72'd0);
        cyc();
        rst = 1'b1;
        set1(32'h900);
        cyc();
        idle();
        chk("post_rst_head",  72'(iq.out1_pc),    72'h900);
        chk("post_rst_out2v", 72'(iq.out2_valid), 72'd0);

        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
